// File: rtl/mc_pricing_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mc_pricing_pkg
// Description : Shared types and helpers for the Monte Carlo pricing array:
//               controller state encoding, payoff mode codes and the
//               reduction-sum width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package mc_pricing_pkg;

   // Controller states
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_REDUCE = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   // Payoff mode encoding on the mode input
   localparam logic MODE_CALL = 1'b0;
   localparam logic MODE_PUT  = 1'b1;

   // Width of the cross-lane sum: one lane accumulator plus log2 of the lane count
   function automatic int acc_width(input int data_w, input int npath_log2, input int core_num);
      return data_w + npath_log2 + $clog2(core_num);
   endfunction

endpackage : mc_pricing_pkg
`default_nettype wire

// File: rtl/mc_payoff_lane.sv
`default_nettype none
// ============================================================================
// Module      : mc_payoff_lane
// Description : One payoff/accumulate lane. Computes the call or put payoff
//               of a path sample against the strike and adds it into a
//               private accumulator when enabled. A clear empties the
//               accumulator at the start of each run.
// Revision    : 1.0 - initial release
// ============================================================================
module mc_payoff_lane
   import mc_pricing_pkg::*;
#(
   parameter int DATA_W = 12,
   parameter int ACC_W  = 20
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              clr,
   input  logic [DATA_W-1:0] path,
   input  logic [DATA_W-1:0] k,
   input  logic              mode,
   output logic [ACC_W-1:0]  acc
);

   logic [DATA_W-1:0] payoff;
   logic [ACC_W-1:0]  acc_d;
   logic [ACC_W-1:0]  acc_q;

   // Payoff clamps at zero: out-of-the-money samples contribute nothing
   always_comb begin
      payoff = '0;
      if (mode == MODE_CALL) begin
         if (path > k) payoff = path - k;
      end else begin
         if (k > path) payoff = k - path;
      end
   end

   // Clear wins over accumulate; the clear only occurs while no samples flow
   always_comb begin
      acc_d = acc_q;
      if (clr) begin
         acc_d = '0;
      end else if (en) begin
         acc_d = acc_q + ACC_W'(payoff);
      end
   end

   // Accumulator register
   always_ff @(posedge clk) begin
      if (!rst_n) acc_q <= '0;
      else        acc_q <= acc_d;
   end

   assign acc = acc_q;

endmodule : mc_payoff_lane
`default_nettype wire

// File: rtl/mc_pricing_array.sv
`default_nettype none
// ============================================================================
// Module      : mc_pricing_array
// Description : Monte Carlo option-pricing aggregator. Path samples arriving
//               over valid/ready are dealt round-robin to CORE_NUM payoff
//               lanes; after CORE_NUM << NPATH_LOG2 samples the lane sums are
//               reduced one lane per cycle and the floor-averaged payoff is
//               presented over an output valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module mc_pricing_array
   import mc_pricing_pkg::*;
#(
   parameter int CORE_NUM   = 4,
   parameter int DATA_W     = 12,
   parameter int NPATH_LOG2 = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              mode,
   input  logic [DATA_W-1:0] K,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_path,
   output logic              in_ready,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_price,
   input  logic              out_ready,
   output logic              busy
);

   localparam int PTR_W = $clog2(CORE_NUM);
   localparam int ACC_W = DATA_W + NPATH_LOG2;
   localparam int SUM_W = acc_width(DATA_W, NPATH_LOG2, CORE_NUM);
   localparam int SHIFT = NPATH_LOG2 + PTR_W;
   localparam int CNT_W = SHIFT;

   localparam logic [CNT_W-1:0] CNT_LAST = '1;
   localparam logic [PTR_W-1:0] RED_LAST = PTR_W'(CORE_NUM - 1);

   state_t            state_q,     state_d;
   logic [PTR_W-1:0]  lane_ptr_q,  lane_ptr_d;
   logic [CNT_W-1:0]  cnt_q,       cnt_d;
   logic [PTR_W-1:0]  red_idx_q,   red_idx_d;
   logic [SUM_W-1:0]  sum_q,       sum_d;
   logic [DATA_W-1:0] out_price_q, out_price_d;
   logic [DATA_W-1:0] k_q,         k_d;
   logic              mode_q,      mode_d;

   logic              accept;
   logic              lane_clr;
   logic [SUM_W-1:0]  reduce_sum;
   logic [ACC_W-1:0]  lane_acc [CORE_NUM];

   assign in_ready  = (state_q == ST_RUN);
   assign out_valid = (state_q == ST_DONE);
   assign busy      = (state_q != ST_IDLE);
   assign out_price = out_price_q;
   assign accept    = in_valid && in_ready;

   // Running sum including the lane currently selected by the reducer
   assign reduce_sum = sum_q + SUM_W'(lane_acc[red_idx_q]);

   // Lanes: only the lane under the dispatch pointer sees the accepted sample
   for (genvar g = 0; g < CORE_NUM; g++) begin : g_lane
      mc_payoff_lane #(
         .DATA_W (DATA_W),
         .ACC_W  (ACC_W)
      ) u_lane (
         .clk   (clk),
         .rst_n (rst_n),
         .en    (accept && (lane_ptr_q == PTR_W'(g))),
         .clr   (lane_clr),
         .path  (in_path),
         .k     (k_q),
         .mode  (mode_q),
         .acc   (lane_acc[g])
      );
   end

   // Next-state, dispatch and reduction control
   always_comb begin
      state_d     = state_q;
      lane_ptr_d  = lane_ptr_q;
      cnt_d       = cnt_q;
      red_idx_d   = red_idx_q;
      sum_d       = sum_q;
      out_price_d = out_price_q;
      k_d         = k_q;
      mode_d      = mode_q;
      lane_clr    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               k_d        = K;
               mode_d     = mode;
               lane_clr   = 1'b1;
               lane_ptr_d = '0;
               cnt_d      = '0;
               red_idx_d  = '0;
               sum_d      = '0;
               state_d    = ST_RUN;
            end
         end
         ST_RUN: begin
            if (accept) begin
               // Both counters are powers of two, so they wrap naturally;
               // the sample counter reaches its wrap exactly at run end.
               lane_ptr_d = lane_ptr_q + 1'b1;
               cnt_d      = cnt_q + 1'b1;
               if (cnt_q == CNT_LAST) begin
                  red_idx_d = '0;
                  state_d   = ST_REDUCE;
               end
            end
         end
         ST_REDUCE: begin
            sum_d     = reduce_sum;
            red_idx_d = red_idx_q + 1'b1;
            if (red_idx_q == RED_LAST) begin
               // Floor divide by the sample count; the quotient fits DATA_W
               out_price_d = DATA_W'(reduce_sum >> SHIFT);
               state_d     = ST_DONE;
            end
         end
         ST_DONE: begin
            if (out_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Control and datapath registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         lane_ptr_q  <= '0;
         cnt_q       <= '0;
         red_idx_q   <= '0;
         sum_q       <= '0;
         out_price_q <= '0;
         k_q         <= '0;
         mode_q      <= MODE_CALL;
      end else begin
         state_q     <= state_d;
         lane_ptr_q  <= lane_ptr_d;
         cnt_q       <= cnt_d;
         red_idx_q   <= red_idx_d;
         sum_q       <= sum_d;
         out_price_q <= out_price_d;
         k_q         <= k_d;
         mode_q      <= mode_d;
      end
   end

endmodule : mc_pricing_array
`default_nettype wire

// File: tb/tb_mc_pricing_array.sv
`default_nettype none
// ============================================================================
// Module      : tb_mc_pricing_array
// Description : Self-checking bench for mc_pricing_array (4 lanes, 12-bit
//               data, 4 samples per lane). Expected prices come from a plain
//               average-of-payoffs model over the whole sample list.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mc_pricing_array;

   localparam int CORE_NUM   = 4;
   localparam int DATA_W     = 12;
   localparam int NPATH_LOG2 = 2;
   localparam int N          = CORE_NUM << NPATH_LOG2;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              start;
   logic              mode;
   logic [DATA_W-1:0] K;
   logic              in_valid;
   logic [DATA_W-1:0] in_path;
   logic              in_ready;
   logic              out_valid;
   logic [DATA_W-1:0] out_price;
   logic              out_ready;
   logic              busy;

   int checks = 0;
   int errors = 0;
   int path_q[$];

   mc_pricing_array #(
      .CORE_NUM   (CORE_NUM),
      .DATA_W     (DATA_W),
      .NPATH_LOG2 (NPATH_LOG2)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .mode      (mode),
      .K         (K),
      .in_valid  (in_valid),
      .in_path   (in_path),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_price (out_price),
      .out_ready (out_ready),
      .busy      (busy)
   );

   // Free-running clock
   always #5 clk = ~clk;

   // Hard stop in case something never completes
   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: floor of the mean payoff over all samples of the run
   function automatic int model_price(input bit m, input int k);
      int total = 0;
      foreach (path_q[i]) begin
         if (m == 1'b0) total += (path_q[i] > k) ? path_q[i] - k : 0;
         else           total += (k > path_q[i]) ? k - path_q[i] : 0;
      end
      return total / N;
   endfunction

   // One complete run over path_q; hold = cycles with out_ready low in DONE
   task automatic do_run(input string tag, input bit m, input int k,
                         input bit gaps, input int hold, input bit start_on_ack);
      int exp_price;
      int lat;
      exp_price = model_price(m, k);
      start = 1'b1; mode = m; K = DATA_W'(k);
      tick();
      start = 1'b0;
      check({tag, "_run_ready"}, in_ready, 1);
      check({tag, "_run_busy"},  busy, 1);
      foreach (path_q[i]) begin
         if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
               in_valid = 1'b0;
               tick();
            end
         end
         in_valid = 1'b1; in_path = DATA_W'(path_q[i]);
         tick();
      end
      in_valid  = 1'b0;
      out_ready = (hold == 0);
      check({tag, "_ready_drop"}, in_ready, 0);
      lat = 0;
      while (out_valid !== 1'b1 && lat < 20) begin
         tick();
         lat++;
      end
      check({tag, "_latency"}, lat, CORE_NUM);
      check({tag, "_price"}, out_price, exp_price);
      for (int c = 0; c < hold; c++) begin
         start = 1'b1;
         tick();
         check({tag, "_hold_valid"}, out_valid, 1);
         check({tag, "_hold_price"}, out_price, exp_price);
         check({tag, "_hold_in_ready"}, in_ready, 0);
         check({tag, "_hold_busy"}, busy, 1);
      end
      out_ready = 1'b1;
      start = start_on_ack;
      tick();
      start = 1'b0;
      check({tag, "_valid_drop"}, out_valid, 0);
      check({tag, "_idle"}, busy, 0);
      check({tag, "_price_kept"}, out_price, exp_price);
   endtask

   initial begin
      int k_r;
      bit m_r;
      rst_n = 1'b0; start = 1'b0; mode = 1'b0; K = '0;
      in_valid = 1'b0; in_path = '0; out_ready = 1'b1;
      tick(); tick();
      check("rst_in_ready",  in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_price", out_price, 0);
      check("rst_busy",      busy, 0);
      rst_n = 1'b1;
      tick();

      // Call, constant in-the-money paths
      path_q.delete();
      repeat (N) path_q.push_back(200);
      do_run("call_basic", 1'b0, 100, 1'b0, 0, 1'b0);

      // Alternating paths, put then call
      path_q.delete();
      for (int i = 0; i < N; i++) path_q.push_back((i % 2 == 0) ? 0 : 400);
      do_run("put_alt", 1'b1, 100, 1'b0, 0, 1'b0);
      check("put_alt_value", out_price, 50);
      do_run("call_alt", 1'b0, 100, 1'b0, 0, 1'b0);
      check("call_alt_value", out_price, 150);

      // Truncation and full-scale
      path_q.delete();
      path_q.push_back(15);
      repeat (N - 1) path_q.push_back(0);
      do_run("trunc", 1'b0, 0, 1'b0, 0, 1'b0);
      path_q.delete();
      repeat (N) path_q.push_back(4095);
      do_run("fullscale", 1'b0, 0, 1'b0, 0, 1'b0);

      // path equal to strike contributes nothing
      path_q.delete();
      repeat (N) path_q.push_back(777);
      do_run("at_money", 1'b1, 777, 1'b0, 0, 1'b0);

      // Randomised runs with input gaps and output backpressure
      for (int r = 0; r < 4; r++) begin
         path_q.delete();
         repeat (N) path_q.push_back(int'($urandom_range(0, 4095)));
         k_r = int'($urandom_range(0, 4095));
         m_r = 1'($urandom_range(0, 1));
         do_run("random", m_r, k_r, 1'b1, (r == 0) ? 5 : int'($urandom_range(0, 3)), 1'b0);
      end

      // Put a known nonzero price on the output, then abort a run with reset
      path_q.delete();
      repeat (N) path_q.push_back(4095);
      do_run("pre_abort", 1'b0, 0, 1'b0, 0, 1'b0);
      start = 1'b1; mode = 1'b0; K = '0;
      tick();
      start = 1'b0;
      repeat (7) begin
         in_valid = 1'b1; in_path = 12'd4000;
         tick();
      end
      in_valid = 1'b0;
      rst_n = 1'b0;
      tick();
      check("abort_in_ready",  in_ready, 0);
      check("abort_out_valid", out_valid, 0);
      check("abort_out_price", out_price, 0);
      check("abort_busy",      busy, 0);
      rst_n = 1'b1;
      tick();
      path_q.delete();
      repeat (N) path_q.push_back(200);
      do_run("post_abort", 1'b0, 100, 1'b0, 0, 1'b0);

      // start during the DONE handshake is ignored; next start works
      do_run("start_on_ack", 1'b0, 100, 1'b0, 2, 1'b1);
      tick();
      check("start_on_ack_still_idle", busy, 0);
      path_q.delete();
      for (int i = 0; i < N; i++) path_q.push_back(100 + 10 * i);
      do_run("after_ack", 1'b1, 300, 1'b0, 0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_mc_pricing_array
`default_nettype wire
